lcd_byte_scheduler: RTL and testbench

LCD_BYTE_SCHEDULER -- requirements
Module: lcd_byte_scheduler

---
 rtl/lcd_byte_scheduler.sv | 155 +++++++++++++++
 tb/tb_lcd_byte_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_scheduler.sv
// Byte scheduler for a 4-bit HD44780-style LCD bus. Replays a fixed
// configuration sequence after the nibble init completes, then arbitrates
// round-robin between two byte requesters and serialises each byte as two
// E-strobed nibbles followed by a command-dependent settle wait.
module lcd_byte_scheduler #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_HI_CYC     = 12,
    parameter int unsigned NIB_GAP_CYC  = 50,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iInitDone,
    input  logic       iReq0,
    input  logic       iReq1,
    input  logic       iRS0,
    input  logic       iRS1,
    input  logic [7:0] iData0,
    input  logic [7:0] iData1,
    output logic       oAck0,
    output logic       oAck1,
    output logic       oReady,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [3:0] {
        WAIT_INIT, CFG_LOAD, ARB, SET_HI, E_HI, GAP, SET_LO, E_LO, WAIT
    } state_t;

    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
    localparam logic [31:0] E_HI_LAST  = 32'(E_HI_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(NIB_GAP_CYC - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  cfg_idx_q, cfg_idx_d;
    logic        ptr_q, ptr_d;
    logic        ready_q, ready_d;
    logic        rs_q, rs_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] wait_last;

    // Function set 4-bit/2-line, entry mode increment, display on, clear.
    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_byte = 8'h28;
            2'd1:    cfg_byte = 8'h06;
            2'd2:    cfg_byte = 8'h0C;
            default: cfg_byte = 8'h01;
        endcase
    endfunction

    // Next-state, arbitration and byte latch selection.
    always_comb begin
        state_d   = state_q;
        cfg_idx_d = cfg_idx_q;
        ptr_d     = ptr_q;
        ready_d   = ready_q;
        rs_d      = rs_q;
        byte_d    = byte_q;
        oAck0     = 1'b0;
        oAck1     = 1'b0;
        // Clear/home commands need the long settle time.
        wait_last = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
                    ? CLR_LAST : CMD_LAST;
        case (state_q)
            WAIT_INIT: if (iInitDone) state_d = CFG_LOAD;
            CFG_LOAD: begin
                rs_d    = 1'b0;
                byte_d  = cfg_byte(cfg_idx_q);
                state_d = SET_HI;
            end
            ARB: begin
                // Pointer only matters when both requesters are pending.
                if (ready_q && !Reset) begin
                    if (iReq0 && (!iReq1 || !ptr_q)) begin
                        oAck0   = 1'b1;
                        rs_d    = iRS0;
                        byte_d  = iData0;
                        ptr_d   = 1'b1;
                        state_d = SET_HI;
                    end else if (iReq1) begin
                        oAck1   = 1'b1;
                        rs_d    = iRS1;
                        byte_d  = iData1;
                        ptr_d   = 1'b0;
                        state_d = SET_HI;
                    end
                end
            end
            SET_HI: if (cnt_q == SETUP_LAST) state_d = E_HI;
            E_HI:   if (cnt_q == E_HI_LAST)  state_d = GAP;
            GAP:    if (cnt_q == GAP_LAST)   state_d = SET_LO;
            SET_LO: if (cnt_q == SETUP_LAST) state_d = E_LO;
            E_LO:   if (cnt_q == E_HI_LAST)  state_d = WAIT;
            WAIT: begin
                if (cnt_q == wait_last) begin
                    if (ready_q) begin
                        state_d = ARB;
                    end else if (cfg_idx_q == 2'd3) begin
                        ready_d = 1'b1;
                        state_d = ARB;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 2'd1;
                        state_d   = CFG_LOAD;
                    end
                end
            end
            default: state_d = WAIT_INIT;
        endcase
        // Single shared delay counter restarts on every state change.
        cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    end

    // State, counter and control registers; byte/RS are plain data latches.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= WAIT_INIT;
            cnt_q     <= 32'd0;
            cfg_idx_q <= 2'd0;
            ptr_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_idx_q <= cfg_idx_d;
            ptr_q     <= ptr_d;
            ready_q   <= ready_d;
        end
        rs_q   <= rs_d;
        byte_q <= byte_d;
    end

    // LCD pins decoded from the current state and latched byte.
    always_comb begin
        oBusy               = state_q inside {SET_HI, E_HI, GAP, SET_LO, E_LO, WAIT};
        oReady              = ready_q;
        oLCD_ReadWrite      = 1'b0;
        oLCD_Enabled        = (state_q == E_HI) || (state_q == E_LO);
        oLCD_RegisterSelect = oBusy ? rs_q : 1'b0;
        case (state_q)
            SET_HI, E_HI, GAP:  oLCD_Data = byte_q[7:4];
            SET_LO, E_LO, WAIT: oLCD_Data = byte_q[3:0];
            default:            oLCD_Data = 4'h0;
        endcase
    end

endmodule

// File: tb/tb_lcd_byte_scheduler.sv
// Randomised bench for lcd_byte_scheduler with a transaction-level model:
// expected byte stream, round-robin grant prediction, per-byte pin timing.
module tb_lcd_byte_scheduler;

    localparam int SU = 2;
    localparam int EH = 4;
    localparam int GP = 6;
    localparam int CW = 20;
    localparam int LW = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       ack0, ack1, ready, busy, e, rs, rw;
    logic [3:0] data;

    int errors = 0;
    int checks = 0;

    lcd_byte_scheduler #(
        .SETUP_CYC(SU), .E_HI_CYC(EH), .NIB_GAP_CYC(GP),
        .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(LW)
    ) dut (
        .Clock(clk), .Reset(rst), .iInitDone(init_done),
        .iReq0(req0), .iReq1(req1), .iRS0(rs0), .iRS1(rs1),
        .iData0(d0), .iData1(d1), .oAck0(ack0), .oAck1(ack1),
        .oReady(ready), .oBusy(busy), .oLCD_Enabled(e),
        .oLCD_RegisterSelect(rs), .oLCD_ReadWrite(rw), .oLCD_Data(data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [8:0] exp_q[$];
    int         cfg_left;
    logic       ptr_m;
    logic       prev_busy;
    logic [8:0] cur;
    logic       seg_e;
    int         seg_len;
    int         seg_idx;
    int         segs[8];

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(9'h028);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        cfg_left  = 4;
        ptr_m     = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic finish_byte();
        int wait_exp;
        wait_exp = (!cur[8] && cur[7:0] >= 8'h01 && cur[7:0] <= 8'h03) ? LW : CW;
        if (seg_idx < 8) segs[seg_idx] = seg_len;
        seg_idx++;
        check("segments", seg_idx, 5);
        if (seg_idx == 5) begin
            check("setup_hi", segs[0], SU);
            check("e_hi_width", segs[1], EH);
            check("gap_plus_setup", segs[2], GP + SU);
            check("e_lo_width", segs[3], EH);
            check("post_wait", segs[4], wait_exp);
        end
    endtask

    task automatic mon_step();
        logic [1:0] exp_ack;
        logic [3:0] exp_nib;
        if (rst) begin
            model_reset();
            return;
        end
        exp_ack = 2'b00;
        if (ready && !busy) begin
            if (req0 && req1)  exp_ack = ptr_m ? 2'b10 : 2'b01;
            else if (req0)     exp_ack = 2'b01;
            else if (req1)     exp_ack = 2'b10;
        end
        check("ack", {ack1, ack0}, exp_ack);
        if (ack0) begin exp_q.push_back({rs0, d0}); ptr_m = 1'b1; end
        if (ack1) begin exp_q.push_back({rs1, d1}); ptr_m = 1'b0; end
        if (!busy) begin
            if (prev_busy) finish_byte();
            check("ready", ready, cfg_left == 0);
            check("idle_pins", {e, rs, rw, (ready ? data : 4'h0)}, 0);
        end else begin
            if (!prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 0, 1);
                    cur = 9'h000;
                end else begin
                    cur = exp_q.pop_front();
                    if (cfg_left > 0) cfg_left--;
                end
                seg_e   = e;
                seg_len = 1;
                seg_idx = 0;
            end else if (e == seg_e) begin
                seg_len++;
            end else begin
                if (seg_idx < 8) segs[seg_idx] = seg_len;
                seg_idx++;
                seg_e   = e;
                seg_len = 1;
            end
            // Upper nibble through the gap, lower nibble from its setup on.
            if (seg_idx < 2 || (seg_idx == 2 && seg_len <= GP)) exp_nib = cur[7:4];
            else                                                 exp_nib = cur[3:0];
            check("nibble", data, exp_nib);
            check("rs_busy", {rs, rw}, {cur[8], 1'b0});
        end
        prev_busy = busy;
    endtask

    task automatic send(input int n, input logic r, input logic [7:0] d);
        bit got = 0;
        @(posedge clk); #1;
        if (n == 0) begin rs0 = r; d0 = d; req0 = 1'b1; end
        else        begin rs1 = r; d1 = d; req1 = 1'b1; end
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (n == 0 ? ack0 : ack1) got = 1;
        end
        if (!got) check("ack_timeout", 0, 1);
        @(posedge clk); #1;
        if (n == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (ready && !busy && !req0 && !req1) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (ready) ok = 1;
        end
        check("ready_reached", ok, 1);
    endtask

    task automatic pulse_init();
        @(posedge clk); #1;
        init_done = 1'b1;
        @(posedge clk); #1;
        init_done = 1'b0;
    endtask

    function automatic logic [7:0] rbyte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(1, 3));
        return 8'($urandom);
    endfunction

    task automatic check_reset_pins(input string tag);
        check(tag, {e, rs, rw, data, ack1, ack0, ready, busy}, 0);
    endtask

    initial begin
        model_reset();
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_pins("reset_state");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_xfer_before_init", busy, 0);

        // Request pending before configuration finishes
        fork
            send(0, 1'b1, 8'h5A);
        join_none
        repeat (3) @(posedge clk);
        pulse_init();
        wait_ready();
        wait_idle();

        send(0, 1'b1, 8'h41);
        wait_idle();
        send(1, 1'b0, 8'h01);
        wait_idle();
        send(1, 1'b0, 8'h0C);
        wait_idle();

        // Both requesters continuously pending
        fork
            for (int i = 0; i < 4; i++) send(0, 1'($urandom), rbyte());
            for (int j = 0; j < 4; j++) send(1, 1'($urandom), rbyte());
        join
        wait_idle();

        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            case ($urandom_range(0, 2))
                0: send(0, 1'($urandom), rbyte());
                1: send(1, 1'($urandom), rbyte());
                default: fork
                    send(0, 1'($urandom), rbyte());
                    send(1, 1'($urandom), rbyte());
                join
            endcase
        end
        wait_idle();

        // Reset while E is high for a data byte
        fork
            send(0, 1'b1, 8'hA7);
        join_none
        begin
            bit seen = 0;
            for (int i = 0; i < 500 && !seen; i++) begin
                @(negedge clk);
                if (e && ready) seen = 1;
            end
            check("e_high_seen", seen, 1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_pins("reset_mid_e_hi");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_xfer_before_reinit", busy, 0);
        pulse_init();
        wait_ready();
        send(1, 1'b1, 8'h33);
        wait_idle();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
